// File: rtl/aes_uart_sequencer.sv
// AES/UART block sequencer: pops a 128-bit block from the receive buffer,
// runs it through the AES core, and streams the result out byte by byte.
//
// Ports:
//   clk, reset           clock, async active-high reset
//   buf_empty/block/of   receive buffer status, block data, overflow flag
//   buf_read_en          one-cycle pop strobe to the buffer
//   aes_start/din        AES launch strobe and plaintext (held in WAIT_AES)
//   aes_done/dout        AES completion pulse and result
//   tx_start/din/done    UART byte handshake, MSB byte first
//   busy                 high outside IDLE
//   err_timeout          sticky, AES never answered
//   err_overflow         sticky, buffer reported overflow
//   blocks_done          count of fully transmitted blocks (wraps)
module aes_uart_sequencer #(
  parameter int AES_TIMEOUT = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             buf_empty,
  input  logic [127:0]     buf_block,
  input  logic             buf_of,
  output logic             buf_read_en,
  output logic             aes_start,
  output logic [127:0]     aes_din,
  input  logic             aes_done,
  input  logic [127:0]     aes_dout,
  output logic             tx_start,
  output logic [7:0]       tx_din,
  input  logic             tx_done,
  output logic             busy,
  output logic             err_timeout,
  output logic             err_overflow,
  output logic [CNT_W-1:0] blocks_done
);

  localparam int TW = $clog2(AES_TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(AES_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_WAIT_AES = 3'd2;
  localparam logic [2:0] S_SEND     = 3'd3;
  localparam logic [2:0] S_WAIT_TX  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [127:0]     block_q, block_d;
  logic [127:0]     out_q, out_d;
  logic [3:0]       byte_idx_q, byte_idx_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             err_to_q, err_to_d;
  logic             err_ovf_q, err_ovf_d;
  logic [CNT_W-1:0] blocks_q, blocks_d;

  logic rd, st_aes, st_tx;

  always_comb begin
    state_d    = state_q;
    block_d    = block_q;
    out_d      = out_q;
    byte_idx_d = byte_idx_q;
    timer_d    = timer_q;
    err_to_d   = err_to_q;
    err_ovf_d  = err_ovf_q | buf_of;
    blocks_d   = blocks_q;
    rd         = 1'b0;
    st_aes     = 1'b0;
    st_tx      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!buf_empty) begin
          rd      = 1'b1;
          block_d = buf_block;
          state_d = S_START;
        end
      end
      S_START: begin
        st_aes  = 1'b1;
        timer_d = '0;
        state_d = S_WAIT_AES;
      end
      S_WAIT_AES: begin
        timer_d = timer_q + TW'(1);
        // a result arriving on the last allowed cycle still wins
        if (aes_done) begin
          out_d      = aes_dout;
          byte_idx_d = '0;
          state_d    = S_SEND;
        end else if (timer_q == T_LAST) begin
          err_to_d = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_SEND: begin
        st_tx   = 1'b1;
        state_d = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (tx_done) begin
          if (byte_idx_q == 4'hF) begin
            blocks_d = blocks_q + CNT_W'(1);
            state_d  = S_IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 4'd1;
            state_d    = S_SEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      block_q    <= '0;
      out_q      <= '0;
      byte_idx_q <= '0;
      timer_q    <= '0;
      err_to_q   <= 1'b0;
      err_ovf_q  <= 1'b0;
      blocks_q   <= '0;
    end else begin
      state_q    <= state_d;
      block_q    <= block_d;
      out_q      <= out_d;
      byte_idx_q <= byte_idx_d;
      timer_q    <= timer_d;
      err_to_q   <= err_to_d;
      err_ovf_q  <= err_ovf_d;
      blocks_q   <= blocks_d;
    end
  end

  // strobes are combinational; mask them so reset forces every output low
  assign buf_read_en  = rd & ~reset;
  assign aes_start    = st_aes & ~reset;
  assign tx_start     = st_tx & ~reset;
  assign aes_din      = block_q;
  // byte i sits at bits 127-8i down; that top bit is {~i, 3'b111}
  assign tx_din       = out_q[{~byte_idx_q, 3'b111} -: 8];
  assign busy         = (state_q != S_IDLE);
  assign err_timeout  = err_to_q;
  assign err_overflow = err_ovf_q;
  assign blocks_done  = blocks_q;

endmodule
